// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared mode encoding, parameter legality check and slice-width helper
package pipe_adder_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    localparam int MIN_WIDTH  = 2;
    localparam int MAX_WIDTH  = 64;
    localparam int MAX_STAGES = 8;

    function automatic bit params_ok(input int width, input int stages);
        return width >= MIN_WIDTH && width <= MAX_WIDTH &&
               stages >= 1 && stages <= MAX_STAGES && (width % stages) == 0;
    endfunction

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// pipe_adder_slice: one SW-bit adder slice plus its valid, carry, operand and partial-sum registers
module pipe_adder_slice #(
    parameter int WIDTH = 8,
    parameter int SW    = 4,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             v_i,
    input  logic             c_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] s_i,
    output logic             v_q,
    output logic             c_q,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] s_q
);
    logic [SW:0]      sum;
    logic             v_d, c_d;
    logic [WIDTH-1:0] a_d, b_d, s_d, s_n;

    always_comb begin
        sum = {1'b0, a_i[K*SW +: SW]} + {1'b0, b_i[K*SW +: SW]} + {{SW{1'b0}}, c_i};
        s_n = s_i;
        s_n[K*SW +: SW] = sum[SW-1:0];
        v_d = adv ? v_i : v_q;
        c_d = adv ? sum[SW] : c_q;
        a_d = adv ? a_i : a_q;
        b_d = adv ? b_i : b_q;
        s_d = adv ? s_n : s_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
        end else begin
            v_q <= v_d;
            c_q <= c_d;
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep carry-pipelined adder/subtractor with valid/ready handshakes
// on both sides; each stage resolves one SW-bit slice using the carry registered upstream.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter bit INV_S  = 1'b0,
    parameter bit INV_CO = 1'b0
) (
    input  logic             CK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OV,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);
    localparam int SW = slice_w(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipe_adder: WIDTH must be 2..64, STAGES 1..8, and WIDTH divisible by STAGES");
    end

    logic             is_sub;
    logic [STAGES:0]  v_w, c_w, rdy;
    logic [WIDTH-1:0] a_w [STAGES+1];
    logic [WIDTH-1:0] b_w [STAGES+1];
    logic [WIDTH-1:0] s_w [STAGES+1];
    logic             unused_lsbs;

    // Subtraction is A + ~B + !CI, so B and the carry are conditioned before stage 0.
    assign is_sub = mode_e'(SUB) == MODE_SUB;
    assign v_w[0] = IN_VALID;
    assign c_w[0] = is_sub ? !CI : CI;
    assign a_w[0] = A;
    assign b_w[0] = is_sub ? ~B : B;
    assign s_w[0] = '0;

    // A stage advances when empty or when its successor advances; this chain is the
    // only combinational path and runs from OUT_READY back to IN_READY.
    always_comb begin
        rdy[STAGES] = OUT_READY;
        for (int k = STAGES - 1; k >= 0; k--)
            rdy[k] = !v_w[k+1] || rdy[k+1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_adder_slice #(
            .WIDTH(WIDTH),
            .SW   (SW),
            .K    (k)
        ) u_slice (
            .clk(CK),
            .rst(CLR),
            .adv(rdy[k]),
            .v_i(v_w[k]),
            .c_i(c_w[k]),
            .a_i(a_w[k]),
            .b_i(b_w[k]),
            .s_i(s_w[k]),
            .v_q(v_w[k+1]),
            .c_q(c_w[k+1]),
            .a_q(a_w[k+1]),
            .b_q(b_w[k+1]),
            .s_q(s_w[k+1])
        );
    end

    assign IN_READY  = rdy[0];
    assign OUT_VALID = v_w[STAGES];
    assign S         = s_w[STAGES] ^ {WIDTH{INV_S}};
    assign CO        = c_w[STAGES] ^ INV_CO;
    // Overflow uses the already-conditioned B MSB and the non-inverted sum.
    assign OV = (a_w[STAGES][WIDTH-1] == b_w[STAGES][WIDTH-1]) &&
                (s_w[STAGES][WIDTH-1] != a_w[STAGES][WIDTH-1]);
    assign unused_lsbs = ^{a_w[STAGES][WIDTH-2:0], b_w[STAGES][WIDTH-2:0]};

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed and randomized checks of pipe_adder in 8/2, inverted 8/2 and 32/4 builds
module tb_pipe_adder;
    logic clk = 1'b0;
    logic clr;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    logic [7:0] a0, b0, s0;
    logic       ci0, sub0, iv0, ir0, co0, ov0, ovl0, or0;
    pipe_adder #(.WIDTH(8), .STAGES(2)) u0 (
        .CK(clk), .CLR(clr), .A(a0), .B(b0), .CI(ci0), .SUB(sub0),
        .IN_VALID(iv0), .IN_READY(ir0), .S(s0), .CO(co0), .OV(ov0),
        .OUT_VALID(ovl0), .OUT_READY(or0));

    logic [7:0] a1, b1, s1;
    logic       ci1, sub1, iv1, ir1, co1, ov1, ovl1, or1;
    pipe_adder #(.WIDTH(8), .STAGES(2), .INV_S(1'b1), .INV_CO(1'b1)) u1 (
        .CK(clk), .CLR(clr), .A(a1), .B(b1), .CI(ci1), .SUB(sub1),
        .IN_VALID(iv1), .IN_READY(ir1), .S(s1), .CO(co1), .OV(ov1),
        .OUT_VALID(ovl1), .OUT_READY(or1));

    logic [31:0] a2, b2, s2;
    logic        ci2, sub2, iv2, ir2, co2, ov2, ovl2, or2;
    pipe_adder #(.WIDTH(32), .STAGES(4)) u2 (
        .CK(clk), .CLR(clr), .A(a2), .B(b2), .CI(ci2), .SUB(sub2),
        .IN_VALID(iv2), .IN_READY(ir2), .S(s2), .CO(co2), .OV(ov2),
        .OUT_VALID(ovl2), .OUT_READY(or2));

    task automatic test_reset();
        clr = 1'b1;
        {a0, b0, ci0, sub0, iv0, or0} = '0;
        {a1, b1, ci1, sub1, iv1, or1} = '0;
        {a2, b2, ci2, sub2, iv2, or2} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ovl0, co0, ov0, s0} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_outputs got %h expected 000", {ovl0, co0, ov0, s0});
        end
        n_checks++;
        if (ir0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b expected 1", ir0); end
        n_checks++;
        if ({ovl1, co1, ov1, s1} !== {1'b0, 1'b1, 1'b0, 8'hFF}) begin
            n_fail++;
            $display("FAIL reset_inverted got %h expected 2ff", {ovl1, co1, ov1, s1});
        end
        @(posedge clk);
        #2 clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ir0 !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b expected 1", ir0); end
    endtask

    task automatic test_add_overflow();
        @(posedge clk); #1;
        a0 = 8'h7F; b0 = 8'h01; ci0 = 1'b0; sub0 = 1'b0; iv0 = 1'b1; or0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ovl0 !== 1'b0) begin n_fail++; $display("FAIL ovf_early_valid got %b expected 0", ovl0); end
        @(negedge clk);
        n_checks++;
        if ({ovl0, co0, ov0, s0} !== {1'b1, 1'b0, 1'b1, 8'h80}) begin
            n_fail++;
            $display("FAIL ovf_result got %h expected 580", {ovl0, co0, ov0, s0});
        end
        @(negedge clk);
        n_checks++;
        if (ovl0 !== 1'b0) begin n_fail++; $display("FAIL ovf_single_cycle got %b expected 0", ovl0); end
    endtask

    task automatic test_sub_and_carry();
        @(posedge clk); #1;
        a0 = 8'h10; b0 = 8'h20; ci0 = 1'b1; sub0 = 1'b1; iv0 = 1'b1; or0 = 1'b1;
        @(posedge clk); #1;
        a0 = 8'hFF; b0 = 8'hFF; ci0 = 1'b0; sub0 = 1'b0;
        @(posedge clk); #1;
        iv0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ovl0, co0, ov0, s0} !== {1'b1, 1'b0, 1'b0, 8'hEF}) begin
            n_fail++;
            $display("FAIL sub_result got %h expected 4ef", {ovl0, co0, ov0, s0});
        end
        @(negedge clk);
        n_checks++;
        if ({ovl0, co0, ov0, s0} !== {1'b1, 1'b1, 1'b0, 8'hFE}) begin
            n_fail++;
            $display("FAIL add_carry_result got %h expected 6fe", {ovl0, co0, ov0, s0});
        end
        @(negedge clk);
        n_checks++;
        if (ovl0 !== 1'b0) begin n_fail++; $display("FAIL sub_drain got %b expected 0", ovl0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [5] = '{8'h0F, 8'h80, 8'h55, 8'h01, 8'h33};
        logic [7:0] vb [5] = '{8'h01, 8'h80, 8'hAA, 8'hFF, 8'h44};
        logic [8:0] ve [5] = '{9'h010, 9'h100, 9'h0FF, 9'h100, 9'h077};
        int in_i = 0;
        int out_i = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            or0 = !(c >= 3 && c <= 6);
            iv0 = in_i < 5;
            ci0 = 1'b0; sub0 = 1'b0;
            if (in_i < 5) begin a0 = va[in_i]; b0 = vb[in_i]; end
            @(negedge clk);
            if (c == 3) begin
                n_checks++;
                if (ir0 !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_full got %b expected 0", ir0); end
            end
            if (ovl0 && or0) begin
                n_checks++;
                if (out_i >= 5) begin
                    n_fail++;
                    $display("FAIL b2b_extra_result got %h expected none", {co0, s0});
                end else if ({co0, s0} !== ve[out_i]) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d got %h expected %h", out_i, {co0, s0}, ve[out_i]);
                end
                out_i++;
            end
            if (iv0 && ir0) in_i++;
        end
        iv0 = 1'b0;
        or0 = 1'b1;
        n_checks++;
        if (out_i !== 5 || in_i !== 5) begin
            n_fail++;
            $display("FAIL b2b_count got in=%0d out=%0d expected 5/5", in_i, out_i);
        end
    endtask

    task automatic test_clear();
        @(posedge clk); #1;
        or0 = 1'b0; iv0 = 1'b1; a0 = 8'h01; b0 = 8'h01; ci0 = 1'b0; sub0 = 1'b0;
        @(posedge clk); #1;
        a0 = 8'h02; b0 = 8'h02;
        @(posedge clk); #1;
        iv0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ovl0, s0} !== {1'b1, 8'h02}) begin
            n_fail++;
            $display("FAIL clr_preload got %h expected 102", {ovl0, s0});
        end
        #2 clr = 1'b1;
        #1;
        n_checks++;
        if ({ovl0, s0, ir0} !== {1'b0, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL clr_immediate got %h expected 001", {ovl0, s0, ir0});
        end
        @(posedge clk); #2;
        clr = 1'b0;
        or0 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (ovl0 !== 1'b0) begin n_fail++; $display("FAIL clr_stale_c%0d got %b expected 0", c, ovl0); end
        end
    endtask

    task automatic test_invert();
        @(posedge clk); #1;
        a1 = 8'h00; b1 = 8'h00; ci1 = 1'b0; sub1 = 1'b0; iv1 = 1'b1; or1 = 1'b1;
        @(posedge clk); #1;
        a1 = 8'h05; b1 = 8'h03; ci1 = 1'b0; sub1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ovl1, co1, ov1, s1} !== {1'b1, 1'b1, 1'b0, 8'hFF}) begin
            n_fail++;
            $display("FAIL inv_zero got %h expected 6ff", {ovl1, co1, ov1, s1});
        end
        @(negedge clk);
        n_checks++;
        if ({ovl1, co1, ov1, s1} !== {1'b1, 1'b0, 1'b0, 8'hFD}) begin
            n_fail++;
            $display("FAIL inv_sub got %h expected 4fd", {ovl1, co1, ov1, s1});
        end
    endtask

    task automatic test_latency();
        int lat;
        @(posedge clk); #1;
        a2 = 32'h0001_FFFF; b2 = 32'h0000_0001; ci2 = 1'b0; sub2 = 1'b0; iv2 = 1'b1; or2 = 1'b1;
        @(posedge clk); #1;
        iv2 = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!ovl2 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL latency32 got %0d edges expected 4", lat); end
        n_checks++;
        if ({co2, ov2, s2} !== {1'b0, 1'b0, 32'h0002_0000}) begin
            n_fail++;
            $display("FAIL latency32_result got %h expected 020000", {co2, ov2, s2});
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [33:0] q[$];
        logic [33:0] e, held;
        logic [31:0] be;
        logic [32:0] r;
        bit          hold = 1'b0;
        int          acc = 0;
        int          cyc = 0;
        while ((acc < 10000 || q.size() > 0) && cyc < 60000) begin
            @(posedge clk); #1;
            iv2 = acc < 10000 && $urandom_range(3) != 0;
            a2 = $urandom;
            b2 = $urandom;
            ci2 = 1'($urandom_range(1));
            sub2 = 1'($urandom_range(1));
            or2 = $urandom_range(3) != 0;
            @(negedge clk);
            cyc++;
            if (hold) begin
                n_checks++;
                if ({ovl2, ov2, co2, s2} !== {1'b1, held}) begin
                    n_fail++;
                    $display("FAIL rand_stall_stable got %h expected 1%h", {ovl2, ov2, co2, s2}, held);
                end
            end
            hold = ovl2 && !or2;
            held = {ov2, co2, s2};
            if (ovl2 && or2) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_spurious got %h expected none", {ov2, co2, s2});
                end else begin
                    e = q.pop_front();
                    if ({ov2, co2, s2} !== e) begin
                        n_fail++;
                        $display("FAIL rand_result got %h expected %h", {ov2, co2, s2}, e);
                    end
                end
            end
            if (iv2 && ir2) begin
                be = sub2 ? ~b2 : b2;
                r = {1'b0, a2} + {1'b0, be} + {32'd0, sub2 ? !ci2 : ci2};
                q.push_back({(a2[31] == be[31]) && (r[31] != a2[31]), r});
                acc++;
            end
        end
        iv2 = 1'b0;
        n_checks++;
        if (q.size() != 0 || acc != 10000) begin
            n_fail++;
            $display("FAIL rand_completion got acc=%0d pending=%0d expected 10000/0", acc, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_and_carry();
        test_back_to_back();
        test_clear();
        test_invert();
        test_latency();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/sum width in bits, legal range 2..64.
REQ-002 SHALL have parameter STAGES, default 2: pipeline stage count, legal range 1..8, and WIDTH SHALL be divisible by STAGES (SW = WIDTH/STAGES bits per slice).
REQ-003 SHALL have parameter INV_S, default 0: when 1, the S output is bitwise inverted.
REQ-004 SHALL have parameter INV_CO, default 0: when 1, the CO output is inverted.
REQ-005 CK  input  1  clock; all state updates on the rising edge.
REQ-006 CLR  input  1  reset; asynchronous, active-high.
REQ-007 A, B  input  WIDTH  operands.
REQ-008 CI  input  1  carry-in (add) / borrow-in (subtract).
REQ-009 SUB  input  1  mode: 0 = add, 1 = subtract.
REQ-010 IN_VALID / IN_READY  input / output  1  upstream handshake.
REQ-011 S  output  WIDTH  result.
REQ-012 CO  output  1  carry-out of the MSB.
REQ-013 OV  output  1  two's-complement signed overflow.
REQ-014 OUT_VALID / OUT_READY  output / input  1  downstream handshake.

Function
REQ-015 A transfer SHALL occur on a rising CK edge when IN_VALID and IN_READY are both 1; the output side SHALL behave likewise with OUT_VALID and OUT_READY.
REQ-016 Add mode SHALL compute {CO,S} = A + B + CI; subtract mode SHALL compute A + ~B + !CI, i.e. A - B - CI, where CO = 1 means no borrow.
REQ-017 Stage k SHALL add operand slice k, bits [k*SW +: SW], using the carry registered by stage k-1; stage 0 SHALL use CI in add mode and !CI in subtract mode.
REQ-018 Unprocessed upper operand slices SHALL travel with their transaction; completed lower sum slices SHALL be carried forward so that S is aligned at the last stage.
REQ-019 Each stage SHALL hold one valid bit; stage k SHALL advance when it is empty or when stage k+1 advances; the last stage SHALL advance when OUT_READY is 1; IN_READY SHALL equal the stage-0 advance condition, combinationally.
REQ-020 With OUT_READY held at 1, a transaction accepted at edge n SHALL present OUT_VALID = 1 with its result after edge n+STAGES-1.
REQ-021 Throughput SHALL be one result per cycle; bubbles SHALL collapse under backpressure.
REQ-022 While OUT_VALID = 1 and OUT_READY = 0, S, CO and OV SHALL remain stable.
REQ-023 OV SHALL be 1 when the operand MSBs, taking B inverted in subtract mode, are equal and the S MSB differs from them.
REQ-024 INV_S and INV_CO SHALL apply only to the outputs; OV SHALL be computed on the non-inverted result.
REQ-025 No combinational path SHALL exist from A, B, CI or SUB to any output; the only combinational path SHALL be OUT_READY to IN_READY.
REQ-026 With STAGES = 1 the block SHALL be a single registered stage with latency 1.

Reset
REQ-027 While CLR = 1, all valid bits SHALL be 0 and all data registers SHALL be 0, so OUT_VALID = 0, S = 0 and CO = 0 (before INV_*), and OV = 0.
REQ-028 Asserting CLR mid-operation SHALL discard every in-flight transaction; no partial result SHALL appear after release.
REQ-029 IN_READY SHALL be 1 during and after reset.

Structure
REQ-030 A shared package/include SHALL define the WIDTH/STAGES legality checks and the SW slice-width helper.
REQ-031 The single natural sub-module SHALL be pipe_adder_slice (one SW-bit slice adder plus its valid, carry and data registers), instantiated STAGES times by generate.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-032 A=0x7F, B=0x01, CI=0, SUB=0, OUT_READY=1 -> after 2 edges: S=0x80, CO=0, OV=1, OUT_VALID=1 for one cycle.
REQ-033 A=0x10, B=0x20, CI=1, SUB=1 -> S=0xEF, CO=0, OV=0; then A=0xFF, B=0xFF, CI=0, SUB=0 -> S=0xFE, CO=1.
REQ-034 Five back-to-back transactions with OUT_READY=0 for cycles 3-6 -> IN_READY falls once both stages are full; the five results appear in order with none lost or duplicated.
REQ-035 CLR pulse while two transactions are in flight -> OUT_VALID=0 and S=0 immediately; no stale result appears after release.
REQ-036 INV_S=1, INV_CO=1, A=0x00, B=0x00, CI=0 -> S=0xFF, CO=1, OV=0.
REQ-037 WIDTH=32, STAGES=4, 10k random operations with random stalls -> every output matches the reference model {CO,S}=A±B±CI, with latency exactly 4 when unstalled.
